avg_result_fifo: RTL and testbench

Downstream buffer for the pair-average stage: it accepts 8-bit averaged results on a per-cycle valid strobe and buffers them in a first-word-fall-through FIFO. It presents them to the consumer over a valid/ready handshake. It also tracks frame boundaries (one frame = FRAME_LEN results) and flags overflow when the producer outruns the consumer. The producer has no back-pressure input, so this block absorbs bursts and reports drops instead of stalling.

---
 rtl/avg_pkg.sv | 13 +
 rtl/avg_fifo_mem.sv | 24 ++
 rtl/avg_result_fifo.sv | 94 +++++++++
 tb/tb_avg_result_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared parameters for the pair-average stage and its result buffer
package avg_pkg;

  localparam int AVG_WIDTH      = 8;
  localparam int AVG_FIFO_DEPTH = 16;
  localparam int AVG_FRAME_LEN  = 120;

  // Counter width for a modulo-n counter (never narrower than one bit)
  function automatic int mod_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avg_fifo_mem.sv
// rtl/avg_fifo_mem.sv - FIFO storage array, synchronous write, asynchronous read
module avg_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avg_result_fifo.sv
// rtl/avg_result_fifo.sv - FWFT result buffer with drop detection and frame tracking
module avg_result_fifo
  import avg_pkg::*;
#(
  parameter int WIDTH     = AVG_WIDTH,
  parameter int DEPTH     = AVG_FIFO_DEPTH,
  parameter int FRAME_LEN = AVG_FRAME_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = mod_width(FRAME_LEN);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] frame_cnt;
  logic          pop;
  logic          push;
  logic          drop;
  logic          frame_last;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;

  // A pop frees a slot this cycle, so a push into a full FIFO is accepted alongside it
  assign pop        = out_valid && out_ready;
  assign push       = in_valid && (!full || pop);
  assign drop       = in_valid && full && !pop;
  assign frame_last = (frame_cnt == FW'(FRAME_LEN - 1));

  avg_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

  // Pointer advance on accepted push / pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Frame position counts every strobe, dropped or not, so alignment survives overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_valid && frame_last;
      if (in_valid) begin
        if (frame_last) frame_cnt <= '0;
        else            frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_avg_result_fifo.sv
// tb/tb_avg_result_fifo.sv - self-checking bench for avg_result_fifo
module tb_avg_result_fifo;
  import avg_pkg::*;

  localparam int W  = AVG_WIDTH;
  localparam int D  = AVG_FIFO_DEPTH;
  localparam int FL = AVG_FRAME_LEN;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          frame_done;

  avg_result_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of buffered words plus sticky drop flag and strobe count
  logic [W-1:0] mq[$];
  bit           m_ovf;
  int           m_strobes;
  bit           m_fd;
  bit           m_pop;
  logic [W-1:0] m_pop_data;
  bit           a_pop;
  logic [W-1:0] a_pop_data;

  task automatic model_clear();
    mq.delete();
    m_ovf = 0;
    m_strobes = 0;
    m_fd = 0;
    m_pop = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
  endtask

  // Drive one cycle, record what the DUT presented before the edge, advance the model
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit r);
    bit do_push;
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    a_pop = out_valid && r;
    a_pop_data = out_data;
    m_pop = (mq.size() > 0) && r;
    m_pop_data = m_pop ? mq[0] : '0;
    do_push = v && ((mq.size() < D) || m_pop);
    if (v && !do_push) m_ovf = 1;
    if (m_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (v) m_strobes++;
    m_fd = v && (m_strobes % FL == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== '0)        begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, exp_b[i], 0);
    checks++; if (count !== CW'(3))     begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if (out_data !== 8'h11)   begin errors++; $display("FAIL basic_head got=%h exp=11", out_data); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1);
      checks++; if (a_pop !== 1'b1 || a_pop_data !== exp_b[i])
        begin errors++; $display("FAIL basic_read%0d got=%b/%h exp=1/%h", i, a_pop, a_pop_data, exp_b[i]); end
    end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < D; i++) cycle(1, W'(i), 0);
    checks++; if (full !== 1'b1)      begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== CW'(D))   begin errors++; $display("FAIL ovf_count_full got=%0d exp=%0d", count, D); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    cycle(1, 8'hAA, 0);
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (count !== CW'(D))   begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", count, D); end
    for (int i = 0; i < D; i++) begin
      cycle(0, '0, 1);
      checks++; if (a_pop !== 1'b1 || a_pop_data !== W'(i))
        begin errors++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, a_pop, a_pop_data, W'(i)); end
    end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] first;
    do_reset();
    for (int i = 0; i < D; i++) cycle(1, W'($urandom), 0);
    first = mq[0];
    cycle(1, 8'h55, 1);
    checks++; if (count !== CW'(D))   begin errors++; $display("FAIL fpp_count got=%0d exp=%0d", count, D); end
    checks++; if (a_pop_data !== first) begin errors++; $display("FAIL fpp_head got=%h exp=%h", a_pop_data, first); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < D; i++) begin
      cycle(0, '0, 1);
      checks++; if (a_pop !== 1'b1 || a_pop_data !== m_pop_data)
        begin errors++; $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, a_pop, a_pop_data, m_pop_data); end
    end
    checks++; if (a_pop_data !== 8'h55) begin errors++; $display("FAIL fpp_last got=%h exp=55", a_pop_data); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL fpp_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fpp_overflow_end got=%b exp=0", overflow); end
  endtask

  task automatic test_frame();
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 2 * FL + 10; i++) begin
      cycle(1, W'($urandom), 1);
      checks++; if (frame_done !== m_fd)
        begin errors++; $display("FAIL frame_pulse strobe=%0d got=%b exp=%b", i, frame_done, m_fd); end
      checks++; if (count !== CW'(mq.size()))
        begin errors++; $display("FAIL frame_count strobe=%0d got=%0d exp=%0d", i, count, mq.size()); end
      if (frame_done) begin
        pulses++;
        checks++; if (i != FL && i != 2 * FL)
          begin errors++; $display("FAIL frame_pulse_pos got=%0d exp=%0d_or_%0d", i, FL, 2 * FL); end
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL frame_pulse_total got=%0d exp=2", pulses); end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, W'($urandom), 0);
    for (int i = 0; i < 43; i++) cycle(1, W'($urandom), 1);
    checks++; if (count !== CW'(7))   begin errors++; $display("FAIL arst_pre_count got=%0d exp=7", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== '0)        begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL arst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL arst_full got=%b exp=0", full); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL arst_frame_done got=%b exp=0", frame_done); end
    @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    for (int i = 1; i <= FL + 2; i++) begin
      cycle(1, W'($urandom), 1);
      checks++; if (frame_done !== m_fd)
        begin errors++; $display("FAIL arst_frame strobe=%0d got=%b exp=%b", i, frame_done, m_fd); end
      if (frame_done) begin
        pulses++;
        checks++; if (i != FL) begin errors++; $display("FAIL arst_frame_pos got=%0d exp=%0d", i, FL); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL arst_frame_total got=%0d exp=1", pulses); end
  endtask

  task automatic test_wrap();
    int max_occ = 0;
    bit v;
    bit r;
    do_reset();
    for (int i = 0; i < 240; i++) begin
      if (((i / 30) % 2) == 0) begin
        v = ($urandom_range(3) != 0);
        r = ($urandom_range(3) == 0);
      end else begin
        v = ($urandom_range(3) == 0);
        r = ($urandom_range(3) != 0);
      end
      cycle(v, W'($urandom), r);
      checks++; if (a_pop !== m_pop)
        begin errors++; $display("FAIL wrap_pop cyc=%0d got=%b exp=%b", i, a_pop, m_pop); end
      if (m_pop) begin
        checks++; if (a_pop_data !== m_pop_data)
          begin errors++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", i, a_pop_data, m_pop_data); end
      end
      checks++; if (count !== CW'(mq.size()))
        begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); end
      checks++; if (full !== (mq.size() == D) || empty !== (mq.size() == 0))
        begin errors++; $display("FAIL wrap_flags cyc=%0d got=%b%b exp=%b%b", i, full, empty, mq.size() == D, mq.size() == 0); end
      checks++; if (overflow !== m_ovf)
        begin errors++; $display("FAIL wrap_overflow cyc=%0d got=%b exp=%b", i, overflow, m_ovf); end
      if (mq.size() > max_occ) max_occ = mq.size();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_frame();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
